// File: rtl/rob_commit_scheduler_if.sv
// Dispatch / writeback / commit / flush signal bundle for rob_commit_scheduler.
// master drives requests, completions and control; slave is the scheduler.
interface rob_commit_scheduler_if #(
   parameter int ROB_SEL = 4
);
   logic               dispatch_req_1;
   logic               dispatch_req_2;
   logic               dispatch_grant_1;
   logic               dispatch_grant_2;
   logic [ROB_SEL-1:0] alloc_idx_1;
   logic [ROB_SEL-1:0] alloc_idx_2;
   logic               complete_valid_1;
   logic               complete_valid_2;
   logic [ROB_SEL-1:0] complete_idx_1;
   logic [ROB_SEL-1:0] complete_idx_2;
   logic               commit_stall;
   logic               commit_valid_1;
   logic               commit_valid_2;
   logic [ROB_SEL-1:0] commit_idx_1;
   logic [ROB_SEL-1:0] commit_idx_2;
   logic               violation_detected;
   logic               flush_busy;
   logic               rob_full;
   logic               rob_empty;

   modport master (
      output dispatch_req_1, dispatch_req_2,
      output complete_valid_1, complete_valid_2,
      output complete_idx_1, complete_idx_2,
      output commit_stall, violation_detected,
      input  dispatch_grant_1, dispatch_grant_2,
      input  alloc_idx_1, alloc_idx_2,
      input  commit_valid_1, commit_valid_2,
      input  commit_idx_1, commit_idx_2,
      input  flush_busy, rob_full, rob_empty
   );

   modport slave (
      input  dispatch_req_1, dispatch_req_2,
      input  complete_valid_1, complete_valid_2,
      input  complete_idx_1, complete_idx_2,
      input  commit_stall, violation_detected,
      output dispatch_grant_1, dispatch_grant_2,
      output alloc_idx_1, alloc_idx_2,
      output commit_valid_1, commit_valid_2,
      output commit_idx_1, commit_idx_2,
      output flush_busy, rob_full, rob_empty
   );
endinterface

// File: rtl/rob_commit_scheduler.sv
// 2-wide ROB allocation / in-order commit sequencer with violation flush.
// ROB_SCHED_DUAL_COMMIT_EN enables the second commit port.
module rob_commit_scheduler #(
   parameter int ROB_NUM      = 16,
   parameter int ROB_SEL      = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input logic              clk,
   input logic              reset_n,
   rob_commit_scheduler_if.slave bus
);
   localparam int CW = ROB_SEL + 1;
   localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CW-1:0] ROB_CAP    = CW'(ROB_NUM);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t state_q, state_d;
   logic [FW-1:0] fcnt_q, fcnt_d;

   logic [ROB_SEL-1:0] head_q, head_d;
   logic [ROB_SEL-1:0] tail_q, tail_d;
   logic [CW-1:0]      count_q, count_d;
   logic [ROB_NUM-1:0] valid_q, valid_d;
   logic [ROB_NUM-1:0] done_q, done_d;

   logic               run_ok;
   logic               commit_ok;
   logic [CW-1:0]      free;
   logic [ROB_SEL-1:0] tail_p1;
   logic               grant_1, grant_2;
   logic               commit_1, commit_2;
   logic [ROB_SEL-1:0] c2_idx;
   logic [CW-1:0]      n_grant, n_commit;

   // FSM: state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RUN;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // FSM: next state; a violation inside FLUSH restarts the count
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      unique case (state_q)
         RUN: begin
            if (bus.violation_detected) begin
               state_d = FLUSH;
               fcnt_d  = '0;
            end
         end
         FLUSH: begin
            if (bus.violation_detected) begin
               fcnt_d = '0;
            end else if (fcnt_q == FLUSH_LAST) begin
               state_d = RUN;
               fcnt_d  = '0;
            end else begin
               fcnt_d = fcnt_q + FW'(1);
            end
         end
      endcase
   end

   // FSM: outputs
   always_comb begin
      run_ok         = reset_n && (state_q == RUN) && !bus.violation_detected;
      commit_ok      = run_ok && !bus.commit_stall;
      bus.flush_busy = (state_q == FLUSH);
   end

   // Free space uses the registered count: slots retiring now are not reused
   always_comb begin
      free    = ROB_CAP - count_q;
      tail_p1 = tail_q + ROB_SEL'(1);
      grant_1 = run_ok && bus.dispatch_req_1 && (free != '0);
      grant_2 = grant_1 && bus.dispatch_req_2 && (free >= CW'(2));
   end

   always_comb begin
      commit_1 = commit_ok && (count_q != '0) && done_q[head_q];
`ifdef ROB_SCHED_DUAL_COMMIT_EN
      c2_idx   = head_q + ROB_SEL'(1);
      commit_2 = commit_1 && (count_q >= CW'(2)) && done_q[c2_idx];
`else
      c2_idx   = '0;
      commit_2 = 1'b0;
`endif
   end

   always_comb begin
      bus.dispatch_grant_1 = grant_1;
      bus.dispatch_grant_2 = grant_2;
      bus.alloc_idx_1      = reset_n ? tail_q : '0;
      bus.alloc_idx_2      = reset_n ? tail_p1 : '0;
      bus.commit_valid_1   = commit_1;
      bus.commit_valid_2   = commit_2;
      bus.commit_idx_1     = commit_1 ? head_q : '0;
      bus.commit_idx_2     = commit_2 ? c2_idx : '0;
      bus.rob_full         = (count_q == ROB_CAP);
      bus.rob_empty        = (count_q == '0);
   end

   always_comb begin
      n_grant  = CW'(grant_1) + CW'(grant_2);
      n_commit = CW'(commit_1) + CW'(commit_2);
      head_d   = head_q + ROB_SEL'(commit_1) + ROB_SEL'(commit_2);
      tail_d   = tail_q + ROB_SEL'(grant_1) + ROB_SEL'(grant_2);
      count_d  = count_q + n_grant - n_commit;
      if (bus.violation_detected) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   // Completion first so a retiring entry still ends up cleared
   always_comb begin
      valid_d = valid_q;
      done_d  = done_q;
      if (run_ok) begin
         if (bus.complete_valid_1 && valid_q[bus.complete_idx_1])
            done_d[bus.complete_idx_1] = 1'b1;
         if (bus.complete_valid_2 && valid_q[bus.complete_idx_2])
            done_d[bus.complete_idx_2] = 1'b1;
      end
      if (commit_1) begin
         valid_d[head_q] = 1'b0;
         done_d[head_q]  = 1'b0;
      end
      if (commit_2) begin
         valid_d[c2_idx] = 1'b0;
         done_d[c2_idx]  = 1'b0;
      end
      if (grant_1) begin
         valid_d[tail_q] = 1'b1;
         done_d[tail_q]  = 1'b0;
      end
      if (grant_2) begin
         valid_d[tail_p1] = 1'b1;
         done_d[tail_p1]  = 1'b0;
      end
      if (bus.violation_detected) begin
         valid_d = '0;
         done_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         done_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end
endmodule
